// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: registered grants, last-owner tie break, and burst limiting
// that forces a hand-over after MAX_BURST cycles while the other master is waiting.
module bus_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 8   // legal range 2..255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_wr,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_dout,
  input  logic [DATA_W-1:0] m1_dout,
  output logic              m0_grant,
  output logic              m1_grant,
  output logic [DATA_W-1:0] m0_din,
  output logic [DATA_W-1:0] m1_din,
  output logic              b_req,
  output logic              b_wr,
  output logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_dout,
  input  logic [DATA_W-1:0] b_din,
  output logic              b_owner
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  localparam logic [7:0] TENURE_MAX = 8'(MAX_BURST - 1);

  state_e     state_q, state_d;
  logic [7:0] tenure_q, tenure_d;
  logic       last_owner_q, last_owner_d;

  // last_owner resets to 1 so master 0 wins the first tie after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      tenure_q     <= '0;
      last_owner_q <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      tenure_q     <= tenure_d;
      last_owner_q <= last_owner_d;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (m0_req && m1_req) state_d = last_owner_q ? GNT0 : GNT1;
        else if (m0_req)      state_d = GNT0;
        else if (m1_req)      state_d = GNT1;
      end
      GNT0: begin
        if (m1_req && (!m0_req || tenure_q == TENURE_MAX)) state_d = GNT1;
        else if (!m0_req)                                  state_d = IDLE;
      end
      GNT1: begin
        if (m0_req && (!m1_req || tenure_q == TENURE_MAX)) state_d = GNT0;
        else if (!m1_req)                                  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Tenure restarts on any state change and saturates while a lone owner keeps the bus.
    tenure_d = tenure_q;
    if (state_d != state_q)
      tenure_d = '0;
    else if (state_q != IDLE && tenure_q != TENURE_MAX)
      tenure_d = tenure_q + 8'd1;

    last_owner_d = last_owner_q;
    if (state_d == GNT0 && state_q != GNT0) last_owner_d = 1'b0;
    if (state_d == GNT1 && state_q != GNT1) last_owner_d = 1'b1;
  end

  // Bus mux decodes the registered state only, so a new owner drives the bus in its first granted cycle.
  always_comb begin
    m0_grant = 1'b0;
    m1_grant = 1'b0;
    b_req    = 1'b0;
    b_wr     = 1'b0;
    b_addr   = '0;
    b_dout   = '0;
    b_owner  = 1'b0;
    m0_din   = '0;
    m1_din   = '0;
    unique case (state_q)
      GNT0: begin
        m0_grant = 1'b1;
        b_req    = m0_req;
        b_wr     = m0_wr;
        b_addr   = m0_addr;
        b_dout   = m0_dout;
        m0_din   = b_din;
      end
      GNT1: begin
        m1_grant = 1'b1;
        b_req    = m1_req;
        b_wr     = m1_wr;
        b_addr   = m1_addr;
        b_dout   = m1_dout;
        m1_din   = b_din;
        b_owner  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: the driver queues the expected post-edge outputs,
// a monitor pops and compares them one time unit after every rising edge.
module tb_bus_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              m0_req, m1_req, m0_wr, m1_wr;
  logic [ADDR_W-1:0] m0_addr, m1_addr, b_addr;
  logic [DATA_W-1:0] m0_dout, m1_dout, m0_din, m1_din, b_dout, b_din;
  logic              m0_grant, m1_grant, b_req, b_wr, b_owner;

  bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_wr(m0_wr), .m1_wr(m1_wr),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_dout(m0_dout), .m1_dout(m1_dout),
    .m0_grant(m0_grant), .m1_grant(m1_grant), .m0_din(m0_din), .m1_din(m1_din),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_dout(b_dout),
    .b_din(b_din), .b_owner(b_owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             tag;
    logic              g0, g1, breq, bwr, owner;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dout, din0, din1;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // grant: 0 = none, 1 = master 0, 2 = master 1; bus fields follow the inputs held this cycle.
  task automatic expect_cycle(input string tag, input int grant);
    exp_t e;
    e.tag = tag;
    e.g0 = 1'b0; e.g1 = 1'b0; e.breq = 1'b0; e.bwr = 1'b0; e.owner = 1'b0;
    e.addr = '0; e.dout = '0; e.din0 = '0; e.din1 = '0;
    if (grant == 1) begin
      e.g0 = 1'b1; e.breq = m0_req; e.bwr = m0_wr; e.addr = m0_addr; e.dout = m0_dout; e.din0 = b_din;
    end else if (grant == 2) begin
      e.g1 = 1'b1; e.breq = m1_req; e.bwr = m1_wr; e.addr = m1_addr; e.dout = m1_dout; e.din1 = b_din;
      e.owner = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " m0_grant"}, 64'(m0_grant), 64'd0);
    check({tag, " m1_grant"}, 64'(m1_grant), 64'd0);
    check({tag, " b_req"},    64'(b_req),    64'd0);
    check({tag, " b_wr"},     64'(b_wr),     64'd0);
    check({tag, " b_addr"},   64'(b_addr),   64'd0);
    check({tag, " b_dout"},   b_dout,        64'd0);
    check({tag, " b_owner"},  64'(b_owner),  64'd0);
    check({tag, " m0_din"},   m0_din,        64'd0);
    check({tag, " m1_din"},   m1_din,        64'd0);
  endtask

  // Monitor: compares one queued expectation per clock, decoupled from the driver.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, " m0_grant"}, 64'(m0_grant), 64'(e.g0));
        check({e.tag, " m1_grant"}, 64'(m1_grant), 64'(e.g1));
        check({e.tag, " one_hot"},  64'(m0_grant & m1_grant), 64'd0);
        check({e.tag, " b_req"},    64'(b_req),    64'(e.breq));
        check({e.tag, " b_wr"},     64'(b_wr),     64'(e.bwr));
        check({e.tag, " b_addr"},   64'(b_addr),   64'(e.addr));
        check({e.tag, " b_dout"},   b_dout,        e.dout);
        check({e.tag, " b_owner"},  64'(b_owner),  64'(e.owner));
        check({e.tag, " m0_din"},   m0_din,        e.din0);
        check({e.tag, " m1_din"},   m1_din,        e.din1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0; m0_wr = 1'b0; m1_wr = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_dout = '0; m1_dout = '0; b_din = '0;

    // Outputs during reset, with a request already pending.
    #10 m0_req = 1'b1;
    #2  check_zero("in_reset");
    #5  reset = 1'b0;
    m0_req = 1'b0;

    // Single master write: grant one edge later, fields on the bus immediately.
    @(negedge clk);
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h0001; m0_dout = 64'd2;
    expect_cycle("m0_write", 1);
    @(negedge clk);
    m0_req = 1'b0; m0_wr = 1'b0;
    expect_cycle("m0_release", 0);

    // Fresh reset, then a tie: master 0 first, seamless hand-over to master 1.
    @(negedge clk);
    reset = 1'b1;
    #2 reset = 1'b0;
    m0_addr = 16'h0100; m1_addr = 16'h7000; m0_dout = 64'h11; m1_dout = 64'h22;
    @(negedge clk);
    m0_req = 1'b1; m1_req = 1'b1;
    expect_cycle("tie_m0_first", 1);
    @(negedge clk);
    m0_req = 1'b0;
    expect_cycle("handover_m1", 2);
    @(negedge clk);
    m1_req = 1'b0;
    expect_cycle("idle_after_m1", 0);

    // Both hold request: tie goes to m0 (m1 served last), then 8-cycle alternation.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      m0_req = 1'b1; m1_req = 1'b1;
      expect_cycle($sformatf("burst%0d", i), ((i / 8) % 2 == 0) ? 1 : 2);
    end
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    expect_cycle("burst_end", 0);

    // Lone master 1 keeps the bus for 20 cycles and reads b_din.
    b_din = 64'h2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      m1_req = 1'b1;
      expect_cycle($sformatf("m1_alone%0d", i), 2);
    end
    @(negedge clk);
    m1_req = 1'b0;
    expect_cycle("read_idle", 0);

    // Asynchronous reset in the middle of a GNT1 cycle.
    @(negedge clk);
    m1_req = 1'b1;
    expect_cycle("pre_rst_m1", 2);
    @(negedge clk);
    m0_req = 1'b1;
    expect_cycle("pre_rst_both", 2);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_zero("async_rst");
    #2 reset = 1'b0;
    expect_cycle("post_rst_m0", 1);
    @(negedge clk);
    expect_cycle("post_rst_hold", 1);
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    expect_cycle("final_idle", 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
